// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared sequencer state encoding and scan-word field layout
package scan_seq_pkg;
   localparam int SCAN_LEN_DEF = 112;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT_IN  = 3'd1,
      STROBE    = 3'd2,
      HOLD      = 3'd3,
      LOAD      = 3'd4,
      SHIFT_OUT = 3'd5,
      RESP      = 3'd6
   } state_t;
   localparam int SEL_MSB    = 111;
   localparam int ADDR0_MSB  = 107;
   localparam int DIN0_MSB   = 91;
   localparam int CSB0       = 59;
   localparam int WEB0       = 58;
   localparam int WMASK0_MSB = 57;
   localparam int ADDR1_MSB  = 53;
   localparam int DIN1_MSB   = 37;
   localparam int CSB1       = 5;
   localparam int WEB1       = 4;
   localparam int WMASK1_MSB = 3;
endpackage

// File: rtl/scan_shifter.sv
// scan_shifter: parallel-load shift register, MSB-first serial out, LSB-in serial capture
module scan_shifter #(
   parameter int W = 112
) (
   input  logic         gpio_clk,
   input  logic         gpio_resetn,
   input  logic         load,
   input  logic         shift,
   input  logic         sin,
   input  logic [W-1:0] din,
   output logic [W-1:0] nxt
);
   logic [W-1:0] q;
   assign nxt = load ? din : shift ? {q[W-2:0], sin} : q;
   // next value is exported so callers can register outputs from it without an extra cycle
   always_ff @(posedge gpio_clk)
      if (!gpio_resetn) q <= '0;
      else q <= nxt;
endmodule

// File: rtl/scan_cmd_sequencer.sv
// scan_cmd_sequencer: parallel SRAM commands to GPIO scan protocol; SCAN_CHECK_EN adds read-back compare
module scan_cmd_sequencer
   import scan_seq_pkg::*;
#(
   parameter int SCAN_LEN      = SCAN_LEN_DEF,
   parameter int STROBE_CYCLES = 1
) (
   input  logic                gpio_clk,
   input  logic                gpio_resetn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_read,
   input  logic [SCAN_LEN-1:0] cmd_word,
   input  logic [SCAN_LEN-1:0] cmd_expect,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_read,
   output logic [SCAN_LEN-1:0] resp_word,
   output logic                gpio_scan,
   output logic                gpio_in,
   output logic                gpio_sram_load,
   output logic                global_csb,
   input  logic                gpio_out,
`ifdef SCAN_CHECK_EN
   output logic                resp_mismatch,
   output logic [7:0]          mismatch_cnt,
`endif
   output logic                busy
);
   localparam int CW = $clog2(SCAN_LEN);
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic rd_q, accept, enter_resp, bit_last, stb_last;
   logic [SCAN_LEN-1:0] shf_nxt;
   assign cmd_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign busy       = state != IDLE;
   assign accept     = cmd_valid && cmd_ready;
   assign enter_resp = nxt == RESP && state != RESP;
   assign bit_last   = cnt == CW'(SCAN_LEN - 1);
   assign stb_last   = cnt == CW'(STROBE_CYCLES - 1);
   scan_shifter #(.W(SCAN_LEN)) u_shf (
      .gpio_clk   (gpio_clk),
      .gpio_resetn(gpio_resetn),
      .load       (accept),
      .shift      (state == SHIFT_IN || state == SHIFT_OUT),
      .sin        (state == SHIFT_OUT && gpio_out),
      .din        (cmd_word),
      .nxt        (shf_nxt)
   );
   // sequence transitions: shift-in, strobe, then capture and shift-out for reads
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = cmd_valid ? SHIFT_IN : IDLE;
         SHIFT_IN:  nxt = bit_last ? STROBE : SHIFT_IN;
         STROBE:    nxt = stb_last ? (rd_q ? HOLD : RESP) : STROBE;
         HOLD:      nxt = LOAD;
         LOAD:      nxt = SHIFT_OUT;
         SHIFT_OUT: nxt = bit_last ? RESP : SHIFT_OUT;
         RESP:      nxt = resp_ready ? IDLE : RESP;
         default:   nxt = IDLE;
      endcase
   end
   // state, counter and pin outputs registered from the next state so pins are glitch-free flops
   always_ff @(posedge gpio_clk)
      if (!gpio_resetn) begin
         state          <= IDLE;
         cnt            <= '0;
         rd_q           <= 1'b0;
         gpio_scan      <= 1'b0;
         gpio_in        <= 1'b0;
         gpio_sram_load <= 1'b0;
         global_csb     <= 1'b1;
         resp_word      <= '0;
         resp_read      <= 1'b0;
      end else begin
         state          <= nxt;
         cnt            <= nxt != state ? '0 : cnt + CW'(1);
         gpio_scan      <= nxt == SHIFT_IN || nxt == SHIFT_OUT;
         gpio_in        <= nxt == SHIFT_IN && shf_nxt[SCAN_LEN-1];
         gpio_sram_load <= nxt == LOAD;
         global_csb     <= nxt != STROBE;
         if (accept) rd_q <= cmd_read;
         if (enter_resp) begin
            resp_word <= rd_q ? shf_nxt : '0;
            resp_read <= rd_q;
         end
      end
`ifdef SCAN_CHECK_EN
   logic [SCAN_LEN-1:0] exp_q;
   // unknown read-back bits count as mismatches; counter saturates and clears only on reset
   always_ff @(posedge gpio_clk)
      if (!gpio_resetn) begin
         exp_q         <= '0;
         resp_mismatch <= 1'b0;
         mismatch_cnt  <= '0;
      end else begin
         if (accept) exp_q <= cmd_expect;
         if (enter_resp) resp_mismatch <= rd_q && (shf_nxt !== exp_q);
         if (resp_valid && resp_ready && resp_mismatch && mismatch_cnt != 8'hFF)
            mismatch_cnt <= mismatch_cnt + 8'd1;
      end
`else
   logic unused_expect;
   assign unused_expect = ^cmd_expect;
`endif
endmodule

// File: tb/tb_scan_cmd_sequencer.sv
// tb_scan_cmd_sequencer: scoreboard bench with a scan-chain model for scan_cmd_sequencer
module tb_scan_cmd_sequencer;
   import scan_seq_pkg::*;
   localparam int L = 112;
   typedef struct {
      logic         rd;
      logic [L-1:0] cmd;
      logic [L-1:0] rsp;
      int           acc;
      logic         mm;
   } ent_t;
   logic clk = 1'b0, rstn = 1'b0;
   logic cmd_valid = 1'b0, cmd_read = 1'b0, resp_ready = 1'b0;
   logic [L-1:0] cmd_word = '0, cmd_expect = '0, model_word = '0, chain = '0;
   logic cmd_ready, resp_valid, resp_read, gpio_scan, gpio_in, gpio_sram_load, global_csb, gpio_out, busy;
   logic [L-1:0] resp_word;
`ifdef SCAN_CHECK_EN
   logic resp_mismatch;
   logic [7:0] mismatch_cnt;
   int mm_cnt = 0;
`endif
   ent_t sb[$];
   ent_t e_pop;
   int n_vec = 0, n_err = 0, cyc = 0;
   int n_resp = 0, n_csb = 0, n_scan = 0, n_load = 0, n_viol = 0;
   logic csb_q = 1'b1, rv_q = 1'b0;

   scan_cmd_sequencer dut (
      .gpio_clk      (clk),
      .gpio_resetn   (rstn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_read      (cmd_read),
      .cmd_word      (cmd_word),
      .cmd_expect    (cmd_expect),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_read     (resp_read),
      .resp_word     (resp_word),
      .gpio_scan     (gpio_scan),
      .gpio_in       (gpio_in),
      .gpio_sram_load(gpio_sram_load),
      .global_csb    (global_csb),
      .gpio_out      (gpio_out),
`ifdef SCAN_CHECK_EN
      .resp_mismatch (resp_mismatch),
      .mismatch_cnt  (mismatch_cnt),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // testchip scan register: SRAM load has priority, otherwise shift in from gpio_in
   always @(posedge clk)
      if (gpio_sram_load) chain <= model_word;
      else if (gpio_scan) chain <= {chain[L-2:0], gpio_in};
   assign gpio_out = chain[L-1];

   task automatic chk(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // monitor on the falling edge, away from DUT updates
   always @(negedge clk)
      if (rstn) begin
         if (cmd_valid && cmd_ready)
            sb.push_back(ent_t'{rd: cmd_read, cmd: cmd_word, rsp: cmd_read ? model_word : '0,
                                acc: cyc + 1, mm: cmd_read && (model_word !== cmd_expect)});
         if (gpio_scan) n_scan++;
         if (busy && cmd_ready) n_viol++;
         if (gpio_sram_load) begin
            n_load++;
            if (sb.size() > 0) chk("load_cycle", L'(cyc - sb[0].acc), L'(114));
         end
         if (!global_csb && csb_q) begin
            n_csb++;
            if (sb.size() > 0) chk("sram_word", chain, sb[0].cmd);
         end
         if (resp_valid && !rv_q) begin
            if (sb.size() == 0) chk("spurious_resp", L'(1), L'(0));
            else chk("latency", L'(cyc - sb[0].acc), L'(sb[0].rd ? 227 : 113));
         end
         if (resp_valid && resp_ready && sb.size() > 0) begin
            e_pop = sb.pop_front();
            chk("resp_word", resp_word, e_pop.rsp);
            chk("resp_read", L'(resp_read), L'(e_pop.rd));
`ifdef SCAN_CHECK_EN
            chk("resp_mismatch", L'(resp_mismatch), L'(e_pop.mm));
            chk("mismatch_cnt", L'(mismatch_cnt), L'(mm_cnt));
            if (e_pop.mm && mm_cnt < 255) mm_cnt++;
`endif
            n_resp++;
         end
         csb_q = global_csb;
         rv_q  = resp_valid;
      end else begin
         csb_q = 1'b1;
         rv_q  = 1'b0;
      end

   task automatic chk_reset();
      chk("rst_cmd_ready", L'(cmd_ready), L'(1));
      chk("rst_busy", L'(busy), L'(0));
      chk("rst_gpio_scan", L'(gpio_scan), L'(0));
      chk("rst_gpio_in", L'(gpio_in), L'(0));
      chk("rst_sram_load", L'(gpio_sram_load), L'(0));
      chk("rst_csb", L'(global_csb), L'(1));
      chk("rst_resp_valid", L'(resp_valid), L'(0));
      chk("rst_resp_word", resp_word, '0);
      chk("rst_resp_read", L'(resp_read), L'(0));
`ifdef SCAN_CHECK_EN
      chk("rst_mismatch", L'(resp_mismatch), L'(0));
      chk("rst_mismatch_cnt", L'(mismatch_cnt), L'(0));
`endif
   endtask

   task automatic send(input logic rd, input logic [L-1:0] w, input logic [L-1:0] e);
      @(posedge clk);
      #1;
      cmd_valid  = 1'b1;
      cmd_read   = rd;
      cmd_word   = w;
      cmd_expect = e;
      @(negedge clk);
      for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
      chk("accept", L'(cmd_ready), L'(1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input int target);
      for (int k = 0; k < 600 && n_resp < target; k++) @(negedge clk);
      chk("resp_timeout", L'(n_resp >= target), L'(1));
   endtask

   task automatic run_cmd(input logic rd, input logic [L-1:0] w, input logic [L-1:0] e);
      int r0, c0, s0, l0;
      r0 = n_resp;
      c0 = n_csb;
      s0 = n_scan;
      l0 = n_load;
      send(rd, w, e);
      wait_resp(r0 + 1);
      chk("csb_pulses", L'(n_csb - c0), L'(1));
      chk("scan_cycles", L'(n_scan - s0), L'(rd ? 224 : 112));
      chk("load_pulses", L'(n_load - l0), L'(rd ? 1 : 0));
   endtask

   initial begin
      logic [L-1:0] w1, w2, r1, rw, flip;
      logic [L-1:0] ws[3];
      logic rds[3];
      int r0, c0, bad_rv, bad_rw, bad_rdy, bad_gpio;
      w1 = {4'd0, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF};
      w2 = {4'd1, 16'hBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 4'hA, 16'h1234, 32'hCAFEF00D, 1'b1, 1'b1, 4'h5};
      r1 = {4'd3, 16'd7, 32'd0, 1'b0, 1'b1, 4'h0, 16'd9, 32'd0, 1'b0, 1'b1, 4'h0};
      model_word = '0;
      model_word[SEL_MSB -: 4]   = 4'd3;
      model_word[DIN0_MSB -: 32] = 32'd3;
      model_word[DIN1_MSB -: 32] = 32'd24;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk);
      #1 rstn = 1'b1;
      resp_ready = 1'b1;
      run_cmd(1'b0, w1, '0);
      run_cmd(1'b1, r1, model_word);
      // back-to-back with cmd_valid held high
      ws[0] = w1; ws[1] = r1; ws[2] = w2;
      rds[0] = 1'b0; rds[1] = 1'b1; rds[2] = 1'b0;
      r0 = n_resp;
      c0 = n_csb;
      @(posedge clk);
      #1 cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_read   = rds[i];
         cmd_word   = ws[i];
         cmd_expect = model_word;
         @(negedge clk);
         for (int k = 0; k < 400 && !cmd_ready; k++) @(negedge clk);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      wait_resp(r0 + 3);
      chk("b2b_responses", L'(n_resp - r0), L'(3));
      chk("b2b_csb_pulses", L'(n_csb - c0), L'(3));
      // backpressure
      resp_ready = 1'b0;
      r0 = n_resp;
      send(1'b1, r1, model_word);
      for (int k = 0; k < 600 && !resp_valid; k++) @(negedge clk);
      chk("bp_resp_valid", L'(resp_valid), L'(1));
      rw = resp_word;
      bad_rv = 0; bad_rw = 0; bad_rdy = 0; bad_gpio = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!resp_valid) bad_rv++;
         if (resp_word !== rw) bad_rw++;
         if (cmd_ready) bad_rdy++;
         if (gpio_scan || gpio_in || gpio_sram_load || !global_csb) bad_gpio++;
      end
      chk("bp_valid_drop", L'(bad_rv), L'(0));
      chk("bp_word_change", L'(bad_rw), L'(0));
      chk("bp_cmd_ready", L'(bad_rdy), L'(0));
      chk("bp_gpio_activity", L'(bad_gpio), L'(0));
      @(posedge clk);
      #1 resp_ready = 1'b1;
      wait_resp(r0 + 1);
      // reset during SHIFT_IN cycle 60
      r0 = n_resp;
      c0 = n_csb;
      send(1'b0, w2, '0);
      repeat (60) @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset();
      sb.delete();
`ifdef SCAN_CHECK_EN
      mm_cnt = 0;
`endif
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (300) @(negedge clk);
      chk("abort_no_resp", L'(n_resp - r0), L'(0));
      chk("abort_no_csb", L'(n_csb - c0), L'(0));
      run_cmd(1'b1, r1, model_word);
`ifdef SCAN_CHECK_EN
      flip = L'(1) << (DIN0_MSB - 5);
      run_cmd(1'b1, r1, model_word ^ flip);
      chk("mm_first_flag", L'(resp_mismatch), L'(1));
      chk("mm_first_cnt", L'(mismatch_cnt), L'(1));
      run_cmd(1'b1, r1, model_word);
      chk("mm_second_flag", L'(resp_mismatch), L'(0));
      chk("mm_second_cnt", L'(mismatch_cnt), L'(1));
`else
      flip = '0;
      chk("flip_unused", flip, '0);
`endif
      chk("busy_ready_overlap", L'(n_viol), L'(0));
      chk("sb_drained", L'(sb.size()), L'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
